bus_requester: RTL
==================

Name: bus_requester

Overview:
- Master-side front end for the 4-way round-robin shared bus.
- Accepts one burst command at a time from local logic.
- Raises cyc to the arbiter, waits for its grant, then runs a burst of stb/ack beats on the shared bus.
- Releases cyc with a mandatory idle cycle so the arbiter can rotate ownership to the next master.

Parameters:
- AW, 16, bus address width.
- DW, 16, bus data width.
- LENW, 4, burst length field width; bursts are 1..2^LENW beats.
- TIMEOUT_CYCLES, 64, grant-wait limit, used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_we  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  AW  start address.
- cmd_len  in  LENW  beats minus one.
- cyc  out  1  bus request to arbiter.
- gnt  in  1  this master's one-hot grant from the arbiter (registered there).
- stb  out  1  beat strobe.
- we  out  1  write enable.
- adr  out  AW  beat address.
- dat_o  out  DW  write data.
- dat_i  in  DW  read data.
- ack  in  1  slave beat acknowledge.
- wdata  in  DW  local write data for the current beat.
- wdata_pop  out  1  one-cycle pulse on each acked write beat.
- rdata  out  DW  captured read data.
- rdata_valid  out  1  one-cycle pulse per acked read beat.
- done  out  1  one-cycle pulse when a burst completes.
- err  out  1  one-cycle pulse on grant timeout; tied 0 when the feature is absent.

Behaviour:
- Reset values: cyc=0, stb=0, we=0, adr=0, dat_o=0, rdata=0, cmd_ready=0, wdata_pop=0, rdata_valid=0, done=0, err=0; FSM = IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch we/addr/len into registers, set the beat counter to cmd_len, go to REQ.
  - cyc rises on the next edge.
- REQ:
  - cyc=1, stb=0.
  - The arbiter registers its grant, so the earliest gnt is 1 cycle after cyc.
  - On gnt=1, go to XFER with stb=1 from the next edge.
  - cmd_ready=0 in every state except IDLE.
- XFER:
  - cyc=1, stb=1; adr = latched address + beat index; dat_o = wdata; we = latched we.
  - On ack:
    - Write burst: pulse wdata_pop.
    - Read burst: capture dat_i into rdata and pulse rdata_valid.
    - Increment the address, modulo 2^AW; wrap is silent.
    - Decrement the counter.
  - Ack on the final beat (counter=0): go to RELEASE and pulse done in that same cycle.
  - stb stays high between acks; a slave may take arbitrarily many wait cycles.
- RELEASE:
  - cyc=0, stb=0 for exactly one cycle, then IDLE.
  - This guarantees the arbiter's cyc & gnt term drops and the grant is re-arbitrated.
  - No back-to-back command is accepted without passing IDLE. Minimum per-burst overhead = 3 cycles.
- gnt low while in XFER (arbiter reset or protocol violation): abort to RELEASE immediately, no done, no further pops.
- ack in REQ, IDLE or RELEASE is ignored.
- rst mid-burst: all outputs return to reset values on the next edge; the latched command is discarded; no done.
- cmd_valid in the same cycle as rst is not accepted.

Optional Feature:
- Macro: BUS_REQ_TIMEOUT_EN.
- With the macro: a counter runs in REQ. After TIMEOUT_CYCLES cycles without gnt, go to RELEASE, pulse err, no done, and drop the command.
- Without the macro: REQ waits indefinitely and err is constant 0.

Decomposition:
- Shared package bus_pkg holds:
  - FSM state encoding: IDLE=2'd0, REQ=2'd1, XFER=2'd2, RELEASE=2'd3.
  - Default AW/DW/LENW constants.
  - The number of masters (4).
- One sub-module, bus_req_timer: a loadable down-counter with an expire flag, instantiated only under BUS_REQ_TIMEOUT_EN.

Test Plan:
- Single write: cmd we=1 addr=0x0100 len=0, gnt 1 cycle after cyc, ack same cycle as stb -> one wdata_pop, adr=0x0100, done 1 cycle after ack edge, cyc low exactly 1 cycle before IDLE.
- Read burst: len=3, addr=0x00FE, dat_i 0xA0..0xA3 with 2 wait cycles per beat -> adr 0x00FE, 0x00FF, 0x0100, 0x0101; 4 rdata_valid pulses with matching data; one done.
- Address wrap at AW=16: addr=0xFFFF, len=1 -> adr 0xFFFF then 0x0000.
- Grant loss: gnt drops after beat 1 of 4 -> cyc/stb low next edge, no done, no further pops.
- Reset mid-XFER at beat 2 -> all outputs 0 next edge; new command afterwards completes normally.
- With BUS_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, gnt never asserted -> err pulse after 8 REQ cycles, cyc=0 next cycle, no done.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the round-robin bus requester slice:
// FSM state encoding, default bus widths and the master count.
package bus_pkg;

    localparam int AW_DEF      = 16;
    localparam int DW_DEF      = 16;
    localparam int LENW_DEF    = 4;
    localparam int NUM_MASTERS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } req_state_e;

endpackage

// File: rtl/bus_requester_if.sv
// Shared-bus signal bundle between one requester (master) and the
// arbiter/slave side of the bus.
interface bus_requester_if
    import bus_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) ();
    logic          cyc;
    logic          gnt;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_o;
    logic [DW-1:0] dat_i;
    logic          ack;

    modport master (
        output cyc, stb, we, adr, dat_o,
        input  gnt, dat_i, ack
    );

    modport slave (
        input  cyc, stb, we, adr, dat_o,
        output gnt, dat_i, ack
    );
endinterface

// File: rtl/bus_req_timer.sv
// Loadable down-counter; expired_o is high while the count sits at zero.
module bus_req_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expired_o
);
    logic [W-1:0] cnt_q;

    // Load has priority; otherwise count down while enabled, saturating at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired_o = (cnt_q == '0);
endmodule

// File: rtl/bus_requester.sv
// Master-side front end for the 4-way round-robin shared bus.
// Accepts one burst command, requests the bus, runs stb/ack beats and
// releases cyc for one idle cycle so the arbiter can rotate.
// Optional grant-wait timeout: define BUS_REQ_TIMEOUT_EN.
module bus_requester
    import bus_pkg::*;
#(
    parameter int AW             = AW_DEF,
    parameter int DW             = DW_DEF,
    parameter int LENW           = LENW_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [LENW-1:0] cmd_len,
    bus_requester_if.master bus,
    input  logic [DW-1:0]   wdata,
    output logic            wdata_pop,
    output logic [DW-1:0]   rdata,
    output logic            rdata_valid,
    output logic            done,
    output logic            err
);
    req_state_e      state_q, state_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [LENW-1:0] cnt_q, cnt_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            rdata_valid_q, rdata_valid_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            timeout_hit;

`ifdef BUS_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic timer_load;
    logic timer_expired;

    // Arm the timer when a command is accepted so it counts REQ cycles only.
    assign timer_load = (state_q == IDLE) && cmd_valid;

    bus_req_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .load_val_i (TW'(TIMEOUT_CYCLES - 1)),
        .en_i       (state_q == REQ),
        .expired_o  (timer_expired)
    );

    assign timeout_hit = (state_q == REQ) && timer_expired;
`else
    assign timeout_hit = 1'b0;
`endif

    // State and datapath registers; reset discards any latched command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            addr_q        <= '0;
            cnt_q         <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    // Next-state and beat handling; a lost grant in XFER wins over ack.
    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        done_d        = 1'b0;
        err_d         = 1'b0;
        wdata_pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    addr_d  = cmd_addr;
                    cnt_d   = cmd_len;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.gnt) begin
                    state_d = XFER;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = RELEASE;
                end
            end
            XFER: begin
                if (!bus.gnt) begin
                    state_d = RELEASE;
                end else if (bus.ack) begin
                    if (we_q) begin
                        wdata_pop = 1'b1;
                    end else begin
                        rdata_d       = bus.dat_i;
                        rdata_valid_d = 1'b1;
                    end
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        done_d  = 1'b1;
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // cmd_ready is masked by rst so a command offered during reset is never taken.
    assign cmd_ready   = (state_q == IDLE) && !rst;
    assign bus.cyc     = (state_q == REQ) || (state_q == XFER);
    assign bus.stb     = (state_q == XFER);
    assign bus.we      = (state_q == XFER) && we_q;
    assign bus.adr     = addr_q;
    assign bus.dat_o   = (state_q == XFER) ? wdata : '0;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign done        = done_q;
    assign err         = err_q;
endmodule
